// File: rtl/mvm_noc_arbiter_if.sv
// Bundles every requester, AXIS_S, AXIS_M and response signal of mvm_noc_arbiter.
// slave modport: the arbiter's view. master modport: the requester/NoC side (testbench).
// Requester vectors are packed, with requester i at [i*W +: W].
interface mvm_noc_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DATAW = 128,
    parameter int IDW   = 4,
    parameter int DESTW = 12,
    parameter int USERW = 75
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*DATAW-1:0] req_data;
    logic [NREQ*DESTW-1:0] req_dest;
    logic [NREQ*2-1:0]     req_op;

    logic                  axis_s_tvalid;
    logic                  axis_s_tready;
    logic [DATAW-1:0]      axis_s_tdata;
    logic [IDW-1:0]        axis_s_tid;
    logic [DESTW-1:0]      axis_s_tdest;
    logic [USERW-1:0]      axis_s_tuser;
    logic                  axis_s_tlast;

    logic                  axis_m_tvalid;
    logic                  axis_m_tready;
    logic [DATAW-1:0]      axis_m_tdata;
    logic [IDW-1:0]        axis_m_tid;

    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [DATAW-1:0]      rsp_data;

    logic [NREQ*4-1:0]     outstanding;
    logic                  err_sticky;

    modport slave (
        input  req_valid, req_data, req_dest, req_op,
        output req_ready,
        output axis_s_tvalid, axis_s_tdata, axis_s_tid, axis_s_tdest, axis_s_tuser, axis_s_tlast,
        input  axis_s_tready,
        input  axis_m_tvalid, axis_m_tdata, axis_m_tid,
        output axis_m_tready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        output outstanding, err_sticky
    );

    modport master (
        output req_valid, req_data, req_dest, req_op,
        input  req_ready,
        input  axis_s_tvalid, axis_s_tdata, axis_s_tid, axis_s_tdest, axis_s_tuser, axis_s_tlast,
        output axis_s_tready,
        output axis_m_tvalid, axis_m_tdata, axis_m_tid,
        input  axis_m_tready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        input  outstanding, err_sticky
    );
endinterface

// File: rtl/mvm_noc_arbiter.sv
// Round-robin arbiter sharing the mvm_noc AXIS slave port among NREQ requesters; routes responses back by TID.
// Latency: grant to axis_s_tvalid 1 cycle, one packet/cycle sustained; response path is combinational.
// Backpressure: tready=0 holds the packet register and all req_ready low; requesters at MAXOUT credits are skipped.
// Ports: clk, reset (async, active-high), bus (mvm_noc_arbiter_if.slave) carrying requester,
// AXIS_S, AXIS_M, per-requester response, outstanding-count and err_sticky signals.
module mvm_noc_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATAW  = 128,
    parameter int IDW    = 4,
    parameter int DESTW  = 12,
    parameter int USERW  = 75,
    parameter int MAXOUT = 4
) (
    input  logic clk,
    input  logic reset,
    mvm_noc_arbiter_if.slave bus
);
    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t           state_q;
    logic [DATAW-1:0] tdata_q;
    logic [IDW-1:0]   tid_q;
    logic [DESTW-1:0] tdest_q;
    logic [1:0]       op_q;
    logic [IDW-1:0]   last_q;

    logic [3:0]       cnt_q [NREQ];
    logic [3:0]       cnt_d [NREQ];
    logic             err_q, err_d;

    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  gnt_oh;
    logic [NREQ-1:0]  rsp_vld_c;
    logic [NREQ-1:0]  rsp_acc;
    logic             cap_ok;
    logic             gnt_vld;
    logic [IDW-1:0]   gnt_idx;
    logic             m_rdy_c;
    logic             tid_ok;
    logic [DATAW-1:0] sel_data;
    logic [DESTW-1:0] sel_dest;
    logic [1:0]       sel_op;
    logic [USERW-1:0] tuser_c;
    logic [NREQ*4-1:0] outstanding_c;

    assign cap_ok = (state_q == S_IDLE) || bus.axis_s_tready;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = bus.req_valid[i] && (cnt_q[i] < 4'(MAXOUT));
        end
    end

    // Rotating priority: lowest eligible index above last grant wins, otherwise
    // wrap around to the lowest eligible index at or below it. Scanning downward
    // and overwriting leaves the lowest match in each pass.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (elig[i] && (i > int'(last_q))) begin
                gnt_vld = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
        if (!gnt_vld) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (elig[i] && (i <= int'(last_q))) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IDW'(i);
                end
            end
        end
        gnt_vld = gnt_vld && cap_ok;
    end

    // One-hot grant doubles as the AND-OR select for the payload mux.
    always_comb begin
        sel_data = '0;
        sel_dest = '0;
        sel_op   = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_oh[i] = gnt_vld && (gnt_idx == IDW'(i));
            sel_data  = sel_data | ({DATAW{gnt_oh[i]}} & bus.req_data[i*DATAW +: DATAW]);
            sel_dest  = sel_dest | ({DESTW{gnt_oh[i]}} & bus.req_dest[i*DESTW +: DESTW]);
            sel_op    = sel_op   | ({2{gnt_oh[i]}}     & bus.req_op[i*2 +: 2]);
        end
    end

    assign bus.req_ready = gnt_oh;

    // Output stage: a single packet register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tdata_q <= '0;
            tid_q   <= '0;
            tdest_q <= '0;
            op_q    <= '0;
            last_q  <= IDW'(NREQ - 1);
        end else if (cap_ok) begin
            if (gnt_vld) begin
                state_q <= S_SEND;
                tdata_q <= sel_data;
                tid_q   <= gnt_idx;
                tdest_q <= sel_dest;
                op_q    <= sel_op;
                last_q  <= gnt_idx;
            end else begin
                state_q <= S_IDLE;
            end
        end
    end

    always_comb begin
        tuser_c       = '0;
        tuser_c[10:9] = op_q;
    end

    assign bus.axis_s_tvalid = (state_q == S_SEND);
    assign bus.axis_s_tlast  = (state_q == S_SEND);
    assign bus.axis_s_tdata  = tdata_q;
    assign bus.axis_s_tid    = tid_q;
    assign bus.axis_s_tdest  = tdest_q;
    assign bus.axis_s_tuser  = tuser_c;

    // Response demux. An out-of-range TID matches no requester, so tready
    // stays at its default of 1 and the beat is swallowed.
    assign tid_ok = int'(bus.axis_m_tid) < NREQ;

    always_comb begin
        rsp_vld_c = '0;
        m_rdy_c   = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.axis_m_tid == IDW'(i)) begin
                rsp_vld_c[i] = bus.axis_m_tvalid;
                m_rdy_c      = bus.rsp_ready[i];
            end
            rsp_acc[i] = rsp_vld_c[i] && bus.rsp_ready[i];
        end
    end

    assign bus.rsp_valid     = rsp_vld_c;
    assign bus.axis_m_tready = m_rdy_c;
    assign bus.rsp_data      = bus.axis_m_tdata;

    // Credit counters: a simultaneous grant and response cancel out; a response
    // to a requester with nothing in flight is flagged and the count holds at 0.
    always_comb begin
        err_d = err_q || (bus.axis_m_tvalid && !tid_ok);
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gnt_oh[i] && !rsp_acc[i]) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end else if (!gnt_oh[i] && rsp_acc[i] && (cnt_q[i] != 4'd0)) begin
                cnt_d[i] = cnt_q[i] - 4'd1;
            end
            if (rsp_acc[i] && (cnt_q[i] == 4'd0)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            outstanding_c[i*4 +: 4] = cnt_q[i];
        end
    end

    assign bus.outstanding = outstanding_c;
    assign bus.err_sticky  = err_q;
endmodule

// File: tb/tb_mvm_noc_arbiter.sv
module tb_mvm_noc_arbiter;
    localparam int NREQ   = 4;
    localparam int DATAW  = 128;
    localparam int IDW    = 4;
    localparam int DESTW  = 12;
    localparam int USERW  = 75;
    localparam int MAXOUT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mvm_noc_arbiter_if #(.NREQ(NREQ), .DATAW(DATAW), .IDW(IDW), .DESTW(DESTW), .USERW(USERW)) bus ();

    mvm_noc_arbiter #(.NREQ(NREQ), .DATAW(DATAW), .IDW(IDW), .DESTW(DESTW), .USERW(USERW),
                      .MAXOUT(MAXOUT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [IDW-1:0]  tid;
        logic            tv;
        logic [NREQ-1:0] rr;
        logic [NREQ-1:0] exp_rv;
        logic            exp_tr;
    } rvec_t;

    rvec_t tbl [8];

    // Behavioural reference state for the random phase.
    bit           m_busy;
    logic [127:0] m_data;
    int           m_tid;
    logic [11:0]  m_dest;
    logic [1:0]   m_op;
    int           m_last;
    int           m_cnt [NREQ];
    bit           m_err;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid     = '0;
        bus.req_data      = '0;
        bus.req_dest      = '0;
        bus.req_op        = '0;
        bus.axis_s_tready = 1'b0;
        bus.axis_m_tvalid = 1'b0;
        bus.axis_m_tdata  = '0;
        bus.axis_m_tid    = '0;
        bus.rsp_ready     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [127:0] d, input logic [11:0] dst, input logic [1:0] op);
        bus.req_data[i*DATAW +: DATAW] = d;
        bus.req_dest[i*DESTW +: DESTW] = dst;
        bus.req_op[i*2 +: 2]           = op;
    endtask

    initial begin
        int exp_tid;
        logic [NREQ*4-1:0] exp_out;
        logic [NREQ-1:0] exp_rdy, exp_rv;
        logic exp_mr;
        bit cap, acc;
        int g, idx, t, inc, dec;

        // ---- reset state and single packet from requester 0 ----
        do_reset();
        chk("rst_tvalid", bus.axis_s_tvalid, 0);
        chk("rst_tdata", bus.axis_s_tdata, 0);
        chk("rst_tid", bus.axis_s_tid, 0);
        chk("rst_tdest", bus.axis_s_tdest, 0);
        chk("rst_tuser", bus.axis_s_tuser, 0);
        chk("rst_tlast", bus.axis_s_tlast, 0);
        chk("rst_outstanding", bus.outstanding, 0);
        chk("rst_err", bus.err_sticky, 0);

        set_req(0, 128'hA5, 12'd3, 2'd0);
        bus.req_valid = 4'b0001;
        bus.axis_s_tready = 1'b1;
        #1;
        chk("s1_req_ready", bus.req_ready, 4'b0001);
        chk("s1_tvalid_before", bus.axis_s_tvalid, 0);
        step();
        bus.req_valid = 4'b0000;
        chk("s1_tvalid", bus.axis_s_tvalid, 1);
        chk("s1_tid", bus.axis_s_tid, 0);
        chk("s1_tdest", bus.axis_s_tdest, 3);
        chk("s1_tdata", bus.axis_s_tdata, 128'hA5);
        chk("s1_tuser", bus.axis_s_tuser, 0);
        chk("s1_tlast", bus.axis_s_tlast, 1);
        chk("s1_outstanding0", bus.outstanding[3:0], 1);
        step();
        chk("s1_idle", bus.axis_s_tvalid, 0);

        // ---- all requesters valid, immediate responses: strict rotation ----
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 128'(i + 16), 12'(i), 2'd1);
        bus.req_valid = 4'b1111;
        bus.axis_s_tready = 1'b1;
        bus.rsp_ready = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            exp_tid = k % NREQ;
            chk("rr_tvalid", bus.axis_s_tvalid, 1);
            chk("rr_tid", bus.axis_s_tid, 128'(exp_tid));
            bus.axis_m_tvalid = 1'b1;
            bus.axis_m_tid = IDW'(exp_tid);
            if (k == 5) bus.req_valid = 4'b0000;
        end
        step();
        bus.axis_m_tvalid = 1'b0;
        chk("rr_drained", bus.outstanding, 0);
        chk("rr_idle", bus.axis_s_tvalid, 0);

        // ---- tready held low: packet holds, no grants ----
        do_reset();
        set_req(2, 128'hDEAD_BEEF_0123, 12'h005, 2'd2);
        set_req(1, 128'h1111, 12'h001, 2'd1);
        bus.req_valid = 4'b0100;
        #1;
        chk("bp_first_grant", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = 4'b0110;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("bp_req_ready", bus.req_ready, 0);
            chk("bp_tvalid", bus.axis_s_tvalid, 1);
            chk("bp_tid", bus.axis_s_tid, 2);
            chk("bp_tdata", bus.axis_s_tdata, 128'hDEAD_BEEF_0123);
            chk("bp_tdest", bus.axis_s_tdest, 5);
            chk("bp_tuser", bus.axis_s_tuser, 128'h400);
            step();
        end
        bus.axis_s_tready = 1'b1;
        #1;
        chk("bp_release_grant", bus.req_ready, 4'b0010);
        step();
        chk("bp_next_tid", bus.axis_s_tid, 1);
        chk("bp_next_tuser", bus.axis_s_tuser, 128'h200);
        idle_inputs();

        // ---- credit limit on requester 1 ----
        do_reset();
        set_req(1, 128'h77, 12'h011, 2'd1);
        set_req(2, 128'h88, 12'h022, 2'd3);
        bus.req_valid = 4'b0010;
        bus.axis_s_tready = 1'b1;
        repeat (4) step();
        chk("cr_full", bus.outstanding[7:4], 4);
        chk("cr_blocked", bus.req_ready, 0);
        bus.req_valid = 4'b0110;
        #1;
        chk("cr_other_granted", bus.req_ready, 4'b0100);
        bus.axis_m_tvalid = 1'b1;
        bus.axis_m_tid = 4'd1;
        bus.axis_m_tdata = 128'h5555;
        bus.rsp_ready = 4'b1111;
        #1;
        chk("cr_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("cr_m_tready", bus.axis_m_tready, 1);
        step();
        bus.axis_m_tvalid = 1'b0;
        #1;
        chk("cr_freed", bus.outstanding[7:4], 3);
        chk("cr_regrant", bus.req_ready, 4'b0010);
        step();
        chk("cr_regrant_tid", bus.axis_s_tid, 1);
        bus.req_valid = 4'b0000;
        step();
        chk("cr_out2", bus.outstanding[11:8], 1);

        // ---- response backpressure and invalid TID ----
        bus.axis_m_tvalid = 1'b1;
        bus.axis_m_tid = 4'd2;
        bus.axis_m_tdata = 128'hCAFE;
        bus.rsp_ready = 4'b0000;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("rb_m_tready", bus.axis_m_tready, 0);
            chk("rb_rsp_valid", bus.rsp_valid, 4'b0100);
            chk("rb_rsp_data", bus.rsp_data, 128'hCAFE);
            step();
        end
        chk("rb_held_count", bus.outstanding[11:8], 1);
        bus.rsp_ready = 4'b0100;
        #1;
        chk("rb_accept", bus.axis_m_tready, 1);
        step();
        chk("rb_dec", bus.outstanding[11:8], 0);
        chk("rb_no_err", bus.err_sticky, 0);
        bus.axis_m_tid = 4'd7;
        bus.rsp_ready = 4'b0000;
        #1;
        chk("bad_tid_tready", bus.axis_m_tready, 1);
        chk("bad_tid_rsp_valid", bus.rsp_valid, 0);
        step();
        bus.axis_m_tvalid = 1'b0;
        chk("bad_tid_err", bus.err_sticky, 1);
        step();
        chk("err_sticky_holds", bus.err_sticky, 1);

        // ---- asynchronous reset in SEND with tready low ----
        do_reset();
        set_req(3, 128'h33, 12'h033, 2'd2);
        set_req(0, 128'h44, 12'h044, 2'd0);
        bus.req_valid = 4'b1000;
        step();
        chk("ar_send", bus.axis_s_tvalid, 1);
        bus.req_valid = 4'b1001;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_tvalid_async", bus.axis_s_tvalid, 0);
        chk("ar_cnt_async", bus.outstanding, 0);
        step();
        reset = 1'b0;
        bus.axis_s_tready = 1'b1;
        #1;
        chk("ar_first_grant", bus.req_ready, 4'b0001);
        step();
        chk("ar_first_tid", bus.axis_s_tid, 0);

        // ---- table: response routing ----
        do_reset();
        tbl[0] = '{4'd0,  1'b1, 4'b0001, 4'b0001, 1'b1};
        tbl[1] = '{4'd1,  1'b1, 4'b0000, 4'b0010, 1'b0};
        tbl[2] = '{4'd3,  1'b1, 4'b1000, 4'b1000, 1'b1};
        tbl[3] = '{4'd2,  1'b0, 4'b0100, 4'b0000, 1'b1};
        tbl[4] = '{4'd2,  1'b0, 4'b1011, 4'b0000, 1'b0};
        tbl[5] = '{4'd5,  1'b1, 4'b1111, 4'b0000, 1'b1};
        tbl[6] = '{4'd15, 1'b1, 4'b0000, 4'b0000, 1'b1};
        tbl[7] = '{4'd1,  1'b1, 4'b1101, 4'b0010, 1'b0};
        for (int v = 0; v < 8; v++) begin
            bus.axis_m_tid = tbl[v].tid;
            bus.axis_m_tvalid = tbl[v].tv;
            bus.rsp_ready = tbl[v].rr;
            bus.axis_m_tdata = 128'(v * 1001 + 7);
            #1;
            chk("tbl_rsp_valid", bus.rsp_valid, tbl[v].exp_rv);
            chk("tbl_m_tready", bus.axis_m_tready, tbl[v].exp_tr);
            chk("tbl_rsp_data", bus.rsp_data, 128'(v * 1001 + 7));
            bus.axis_m_tvalid = 1'b0;
            step();
        end

        // ---- randomized traffic against the reference model ----
        do_reset();
        m_busy = 0; m_data = '0; m_tid = 0; m_dest = '0; m_op = '0;
        m_last = NREQ - 1; m_err = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        for (int c = 0; c < 600; c++) begin
            chk("rnd_tvalid", bus.axis_s_tvalid, m_busy);
            if (m_busy) begin
                chk("rnd_tid", bus.axis_s_tid, 128'(m_tid));
                chk("rnd_tdata", bus.axis_s_tdata, m_data);
                chk("rnd_tdest", bus.axis_s_tdest, m_dest);
                chk("rnd_tuser", bus.axis_s_tuser, 128'(m_op) << 9);
            end
            for (int i = 0; i < NREQ; i++) exp_out[i*4 +: 4] = 4'(m_cnt[i]);
            chk("rnd_outstanding", bus.outstanding, exp_out);
            chk("rnd_err", bus.err_sticky, m_err);

            bus.req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++)
                set_req(i, {$urandom, $urandom, $urandom, $urandom}, 12'($urandom), 2'($urandom));
            bus.axis_s_tready = ($urandom_range(0, 3) != 0);
            bus.axis_m_tvalid = 1'($urandom_range(0, 1));
            bus.axis_m_tid = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            bus.axis_m_tdata = {$urandom, $urandom, $urandom, $urandom};
            bus.rsp_ready = 4'($urandom_range(0, 15));
            #1;

            cap = !m_busy || bus.axis_s_tready;
            g = -1;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (g < 0 && bus.req_valid[idx] && m_cnt[idx] < MAXOUT) g = idx;
            end
            if (!cap) g = -1;
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
            t = int'(bus.axis_m_tid);
            if (t < NREQ) begin
                exp_rv = bus.axis_m_tvalid ? 4'(1 << t) : 4'b0000;
                exp_mr = bus.rsp_ready[t];
                acc = bus.axis_m_tvalid && bus.rsp_ready[t];
            end else begin
                exp_rv = 4'b0000;
                exp_mr = 1'b1;
                acc = 0;
                if (bus.axis_m_tvalid) m_err = 1;
            end
            chk("rnd_req_ready", bus.req_ready, exp_rdy);
            chk("rnd_m_tready", bus.axis_m_tready, exp_mr);
            chk("rnd_rsp_valid", bus.rsp_valid, exp_rv);
            chk("rnd_rsp_data", bus.rsp_data, bus.axis_m_tdata);

            if (cap) begin
                if (g >= 0) begin
                    m_busy = 1;
                    m_data = bus.req_data[g*DATAW +: DATAW];
                    m_dest = bus.req_dest[g*DESTW +: DESTW];
                    m_op   = bus.req_op[g*2 +: 2];
                    m_tid  = g;
                    m_last = g;
                end else begin
                    m_busy = 0;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                inc = (g == i) ? 1 : 0;
                dec = (acc && t == i) ? 1 : 0;
                if (dec == 1 && m_cnt[i] == 0) m_err = 1;
                m_cnt[i] = m_cnt[i] + inc - dec;
                if (m_cnt[i] < 0) m_cnt[i] = 0;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
